// File: rtl/video_timing_gen.sv
// video_timing_gen: Mega Drive style VDP raster source with colour bars.
// Latency: all outputs are registered. They change only on the clk that raises ce_pix, and they describe the new hcnt/vcnt.
// Backpressure: none. The raster is free-running, and consumers qualify every output with ce_pix.
//
// Ports:
//   clk, reset_n        master clock (MCLK) and asynchronous active-low reset
//   h40, v30, pal       mode requests (H40 / 240 lines / 313-line frame), sampled at frame wrap only
//   interlace_en        alternating long/short fields, sampled at frame wrap only
//   ce_pix              one-clk pixel strobe
//   hcnt, vcnt          pixel and line index
//   de_h, de_v          horizontal / vertical display enable
//   hs, vs              active-low syncs
//   field               current field (1 = odd, long frame)
//   r, g, b             colour-bar pattern, zero outside the active area
module video_timing_gen #(
    parameter bit BAR_EN = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       h40,
    input  logic       v30,
    input  logic       pal,
    input  logic       interlace_en,
    output logic       ce_pix,
    output logic [8:0] hcnt,
    output logic [8:0] vcnt,
    output logic       de_h,
    output logic       de_v,
    output logic       hs,
    output logic       vs,
    output logic       field,
    output logic [7:0] r,
    output logic [7:0] g,
    output logic [7:0] b
);

    logic [3:0]  div;
    logic        h40_l, v30_l, pal_l, il_l;

    logic        in_hs40, pix_last, h_last, v_last, frame_wrap;
    logic [8:0]  v_last_idx, hn, vn;
    logic        m_h40, m_v30, m_pal, m_il, field_n;
    logic        de_h_n, de_v_n, hs_n, vs_n;
    logic [8:0]  v_act, vs_start;
    logic [2:0]  bar;
    logic [23:0] rgb_n;

    // Counter advance. In H40 the 30 HS pixels are stretched to 10 clk.
    // This keeps the line at 3420 MCLK in both modes.
    always_comb begin
        in_hs40    = (hcnt >= 9'd329) && (hcnt <= 9'd358);
        pix_last   = (div >= ((h40_l && !in_hs40) ? 4'd7 : 4'd9));
        h_last     = (hcnt >= (h40_l ? 9'd419 : 9'd341));
        // The odd field of an interlaced frame carries one extra line.
        v_last_idx = (pal_l ? 9'd312 : 9'd261) + {8'd0, il_l & field};
        v_last     = (vcnt >= v_last_idx);
        frame_wrap = pix_last && h_last && v_last;
        hn         = h_last ? 9'd0 : hcnt + 9'd1;
        vn         = !h_last ? vcnt : (v_last ? 9'd0 : vcnt + 9'd1);
        // New mode applies from pixel 0 of the new frame, so decode uses it already.
        m_h40      = frame_wrap ? h40 : h40_l;
        m_v30      = frame_wrap ? v30 : v30_l;
        m_pal      = frame_wrap ? pal : pal_l;
        m_il       = frame_wrap ? interlace_en : il_l;
        field_n    = frame_wrap ? (interlace_en & ~field) : field;
    end

    // Output decode for the pixel that becomes current on this ce_pix.
    always_comb begin
        de_h_n   = (hn < (m_h40 ? 9'd320 : 9'd256));
        v_act    = m_v30 ? 9'd240 : 9'd224;
        de_v_n   = (vn < v_act);
        hs_n     = m_h40 ? !((hn >= 9'd329) && (hn <= 9'd358))
                         : !((hn >= 9'd265) && (hn <= 9'd290));
        vs_start = v_act + (m_pal ? 9'd35 : 9'd11);
        vs_n     = !((vn >= vs_start) && (vn <= vs_start + 9'd2));
        bar      = 3'd0;
        if (m_h40) begin
            // H40 bars are 40 px wide, so a threshold chain is used instead of a divider.
            for (int i = 1; i < 8; i++) begin
                if (hn >= 9'(40 * i)) begin
                    bar = 3'(i);
                end
            end
        end else begin
            bar = hn[7:5];
        end
        rgb_n = (BAR_EN && de_h_n && de_v_n) ? {{8{bar[2]}}, {8{bar[1]}}, {8{bar[0]}}} : 24'd0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div    <= 4'd0;
            ce_pix <= 1'b0;
            hcnt   <= 9'd0;
            vcnt   <= 9'd0;
            de_h   <= 1'b0;
            de_v   <= 1'b0;
            hs     <= 1'b1;
            vs     <= 1'b1;
            field  <= 1'b0;
            r      <= 8'd0;
            g      <= 8'd0;
            b      <= 8'd0;
            h40_l  <= 1'b0;
            v30_l  <= 1'b0;
            pal_l  <= 1'b0;
            il_l   <= 1'b0;
        end else if (pix_last) begin
            div       <= 4'd0;
            ce_pix    <= 1'b1;
            hcnt      <= hn;
            vcnt      <= vn;
            de_h      <= de_h_n;
            de_v      <= de_v_n;
            hs        <= hs_n;
            vs        <= vs_n;
            field     <= field_n;
            {r, g, b} <= rgb_n;
            h40_l     <= m_h40;
            v30_l     <= m_v30;
            pal_l     <= m_pal;
            il_l      <= m_il;
        end else begin
            div    <= div + 4'd1;
            ce_pix <= 1'b0;
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: raster generator against a pixel-level reference model.
// Latency: model advances on posedge; outputs are compared on every negedge.
// Backpressure: not applicable.
module tb_video_timing_gen;

    localparam int LIMIT = 2_300_000;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic h40 = 1'b0, v30 = 1'b0, pal = 1'b0, interlace_en = 1'b0;

    logic       ce_pix, de_h, de_v, hs, vs, field;
    logic [8:0] hcnt, vcnt;
    logic [7:0] r, g, b;
    logic       nb_ce, nb_de_h, nb_de_v, nb_hs, nb_vs, nb_field;
    logic [8:0] nb_hcnt, nb_vcnt;
    logic [7:0] nb_r, nb_g, nb_b;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    video_timing_gen #(.BAR_EN(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .h40(h40), .v30(v30), .pal(pal),
        .interlace_en(interlace_en), .ce_pix(ce_pix), .hcnt(hcnt), .vcnt(vcnt),
        .de_h(de_h), .de_v(de_v), .hs(hs), .vs(vs), .field(field),
        .r(r), .g(g), .b(b)
    );

    video_timing_gen #(.BAR_EN(1'b0)) dut_nobar (
        .clk(clk), .reset_n(reset_n), .h40(h40), .v30(v30), .pal(pal),
        .interlace_en(interlace_en), .ce_pix(nb_ce), .hcnt(nb_hcnt), .vcnt(nb_vcnt),
        .de_h(nb_de_h), .de_v(nb_de_v), .hs(nb_hs), .vs(nb_vs), .field(nb_field),
        .r(nb_r), .g(nb_g), .b(nb_b)
    );

    // ---------------- reference model: current pixel and how long it has lasted
    int m_h = 0, m_v = 0, m_t = 0;
    bit m_h40 = 0, m_v30 = 0, m_pal = 0, m_il = 0, m_field = 0, m_ce = 0;
    bit m_fresh = 1;

    function automatic int pix_len(input bit w, input int h);
        if (w) return (h >= 329 && h <= 358) ? 10 : 8;
        return 10;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_h = 0; m_v = 0; m_t = 0; m_ce = 0; m_fresh = 1; m_field = 0;
            m_h40 = 0; m_v30 = 0; m_pal = 0; m_il = 0;
        end else begin
            int lines;
            m_ce = 0;
            m_t++;
            if (m_t == pix_len(m_h40, m_h)) begin
                m_t = 0; m_ce = 1; m_fresh = 0;
                m_h++;
                if (m_h == (m_h40 ? 420 : 342)) begin
                    m_h = 0;
                    lines = (m_pal ? 313 : 262) + ((m_il && m_field) ? 1 : 0);
                    m_v++;
                    if (m_v == lines) begin
                        m_v = 0;
                        m_field = interlace_en ? !m_field : 1'b0;
                        m_h40 = h40; m_v30 = v30; m_pal = pal; m_il = interlace_en;
                    end
                end
            end
        end
    end

    function automatic logic [47:0] expect_vec(input bit bars_on);
        bit dh, dv, hsl, vsl;
        int vst, bar;
        logic [7:0] rr, gg, bb;
        if (m_fresh) return {1'b0, 9'd0, 9'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 24'd0};
        dh  = m_h < (m_h40 ? 320 : 256);
        dv  = m_v < (m_v30 ? 240 : 224);
        hsl = m_h40 ? (m_h >= 329 && m_h <= 358) : (m_h >= 265 && m_h <= 290);
        vst = (m_v30 ? 240 : 224) + (m_pal ? 35 : 11);
        vsl = (m_v >= vst) && (m_v < vst + 3);
        bar = m_h40 ? m_h / 40 : m_h / 32;
        rr = 8'd0; gg = 8'd0; bb = 8'd0;
        if (bars_on && dh && dv) begin
            rr = bar[2] ? 8'hFF : 8'h00;
            gg = bar[1] ? 8'hFF : 8'h00;
            bb = bar[0] ? 8'hFF : 8'h00;
        end
        return {m_ce, 9'(m_h), 9'(m_v), dh, dv, !hsl, !vsl, m_field, rr, gg, bb};
    endfunction

    always @(negedge clk) begin
        logic [47:0] e1, e2, a1, a2;
        e1 = expect_vec(1'b1);
        a1 = {ce_pix, hcnt, vcnt, de_h, de_v, hs, vs, field, r, g, b};
        checks++;
        if (a1 !== e1) begin
            errors++;
            $display("FAIL cycle_bars t=%0t act=%h exp=%h", $time, a1, e1);
        end
        e2 = expect_vec(1'b0);
        a2 = {nb_ce, nb_hcnt, nb_vcnt, nb_de_h, nb_de_v, nb_hs, nb_vs, nb_field, nb_r, nb_g, nb_b};
        checks++;
        if (a2 !== e2) begin
            errors++;
            $display("FAIL cycle_nobar t=%0t act=%h exp=%h", $time, a2, e2);
        end
        if (errors >= 40) begin
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
    end

    // ---------------- per-frame statistics taken from DUT outputs at line starts
    int fidx, s_lines, s_dev, s_vsc, s_vsf;
    int flen[4], fdev[4], fvsc[4], fvsf[4], ffld[4];

    always @(negedge clk) begin
        if (!reset_n) begin
            fidx = 0; s_lines = 1; s_dev = 1; s_vsc = 0; s_vsf = -1; ffld[0] = 0;
        end else if (ce_pix && hcnt == 9'd0) begin
            if (vcnt == 9'd0) begin
                if (fidx < 3) begin
                    flen[fidx] = s_lines; fdev[fidx] = s_dev;
                    fvsc[fidx] = s_vsc; fvsf[fidx] = s_vsf;
                    fidx++;
                    ffld[fidx] = int'(field);
                end
                s_lines = 0; s_dev = 0; s_vsc = 0; s_vsf = -1;
            end
            s_lines++;
            if (de_v) s_dev++;
            if (!vs) begin
                if (s_vsf < 0) s_vsf = int'(vcnt);
                s_vsc++;
            end
        end
    end

    // ---------------- helpers
    task automatic tick();
        @(posedge clk);
        #2;
        cyc++;
        if (cyc > LIMIT) begin
            checks++; errors++;
            $display("FAIL timeout act=%0d cycles exp<=%0d", cyc, LIMIT);
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
        end
    endtask

    task automatic wait_v(input int v);
        do tick(); while (int'(vcnt) != v);
    endtask

    task automatic first_ce(input string nm);
        int n;
        reset_n = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!ce_pix && n < 40);
        chk(nm, n, 10);
    endtask

    task automatic measure_line(input bit w, output int clks, output int ces, output int hs_lo,
                                output int hs_first, output int deh, output int bad_iv,
                                output logic [23:0] c0, output logic [23:0] c40,
                                output logic [23:0] c300, output logic [23:0] c320);
        int iv, prev, guard;
        guard = 0;
        do begin tick(); guard++; end while (!(ce_pix && hcnt == 9'd0) && guard < 5000);
        clks = 0; ces = 0; hs_lo = 0; hs_first = -1; deh = 0; bad_iv = 0; iv = 0; prev = 0;
        c0 = '1; c40 = '1; c300 = '1; c320 = '1;
        do begin
            tick(); clks++; iv++;
            if (ce_pix) begin
                ces++;
                if (iv != pix_len(w, prev)) bad_iv++;
                iv = 0;
                prev = int'(hcnt);
                if (!hs) begin
                    if (hs_first < 0) hs_first = int'(hcnt);
                    hs_lo++;
                end
                if (de_h) deh++;
                case (int'(hcnt))
                    0:   c0   = {r, g, b};
                    40:  c40  = {r, g, b};
                    300: c300 = {r, g, b};
                    320: c320 = {r, g, b};
                    default: ;
                endcase
            end
        end while (!(ce_pix && hcnt == 9'd0) && clks < 5000);
    endtask

    // ---------------- stimulus
    initial begin
        int clks, ces, hl, hf, dh, bi, rwait;
        logic [23:0] c0, c40, c300, c320;

        reset_n = 1'b0;
        repeat (4) tick();
        chk("rst_hcnt", int'(hcnt), 0);
        chk("rst_hs", int'(hs), 1);
        chk("rst_de_h", int'(de_h), 0);
        first_ce("first_ce_boot");

        // reset in the middle of line 2
        wait_v(2);
        rwait = $urandom_range(50, 3000);
        repeat (rwait) tick();
        reset_n = 1'b0;
        #1;
        chk("midrst_hcnt", int'(hcnt), 0);
        chk("midrst_vcnt", int'(vcnt), 0);
        chk("midrst_vs", int'(vs), 1);
        chk("midrst_rgb", int'({r, g, b}), 0);
        repeat (3) tick();
        first_ce("first_ce_midrst");

        // H32 NTSC line
        measure_line(1'b0, clks, ces, hl, hf, dh, bi, c0, c40, c300, c320);
        chk("h32_clk_per_line", clks, 3420);
        chk("h32_ce_per_line", ces, 342);
        chk("h32_hs_width", hl, 26);
        chk("h32_hs_start", hf, 265);
        chk("h32_de_h_px", dh, 256);
        chk("h32_ce_spacing_bad", bi, 0);

        // mode inputs thrash mid-frame; only the value at the wrap matters
        while (vcnt < 9'd200) begin
            tick();
            {h40, v30, pal, interlace_en} = 4'($urandom);
        end
        h40 = 1'b1; v30 = 1'b1; pal = 1'b1; interlace_en = 1'b1;

        // frame 1: H40 PAL V30 interlaced, odd field
        wait_v(0);
        wait_v(10);
        measure_line(1'b1, clks, ces, hl, hf, dh, bi, c0, c40, c300, c320);
        chk("h40_clk_per_line", clks, 3420);
        chk("h40_ce_per_line", ces, 420);
        chk("h40_hs_width", hl, 30);
        chk("h40_hs_start", hf, 329);
        chk("h40_de_h_px", dh, 320);
        chk("h40_ce_spacing_bad", bi, 0);
        chk("bar_h0", int'(c0), 32'h000000);
        chk("bar_h40", int'(c40), 32'h0000FF);
        chk("bar_h300", int'(c300), 32'hFFFFFF);
        chk("bar_h320", int'(c320), 32'h000000);

        while (vcnt < 9'd150) begin
            tick();
            {h40, v30, pal} = 3'($urandom);
        end
        h40 = 1'b1; v30 = 1'b1; pal = 1'b1;
        wait_v(160);
        interlace_en = 1'b0;   // dropped during the long field

        wait_v(0);
        wait_v(3);
        chk("f0_lines", flen[0], 262);
        chk("f0_de_v_lines", fdev[0], 224);
        chk("f0_vs_start", fvsf[0], 235);
        chk("f0_vs_lines", fvsc[0], 3);
        chk("f1_field", ffld[1], 1);
        chk("f1_lines", flen[1], 314);
        chk("f1_de_v_lines", fdev[1], 240);
        chk("f1_vs_start", fvsf[1], 275);
        chk("f1_vs_lines", fvsc[1], 3);
        chk("f2_field", ffld[2], 0);
        chk("f2_field_now", int'(field), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
